// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU with a start/busy/done handshake.
//
// The operands and the opcode are captured when a start request is accepted in
// IDLE. Single-cycle operations finish one cycle later, in EXEC. When the
// multiplier is built, MUL runs a WIDTH-iteration shift-add sequence and then
// one completion cycle. Results and flags are registered and held until the
// next completion.
//
// Optional feature macro: ALU_MUL_EN
//   This macro compiles in the MUL state, the iteration counter and the
//   shift-add datapath. Without it, op 011 takes the EXEC path and returns
//   zero.
//
// Opcodes (aluCtrl):
//   000 AND   001 OR    010 ADD   110 SUB
//   111 SLT   100 SLL   101 SRL   011 MUL
//
// Ports:
//   clk      in   clock; all state changes on the rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   srcA     in   [WIDTH] operand A, captured on accept
//   srcB     in   [WIDTH] operand B, captured on accept
//   aluCtrl  in   [3] opcode, captured on accept
//   busy     out  operation in flight
//   done     out  one-cycle completion pulse
//   aluRslt  out  [WIDTH] registered result
//   zero     out  registered (aluRslt == 0)
//   ovf      out  registered signed overflow (ADD/SUB only)
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       aluCtrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluRslt,
  output logic             zero,
  output logic             ovf
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1
`ifdef ALU_MUL_EN
    ,
    ST_MUL  = 2'd2
`endif
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;

`ifdef ALU_MUL_EN
  // The counter must be able to hold WIDTH itself, which marks the
  // completion cycle that follows the last iteration.
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
`endif

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] sum_s;
  logic             add_ovf_s;
  logic             slt_s;
  logic [WIDTH-1:0] exec_rslt_s;
  logic             exec_ovf_s;

  // Single-cycle datapath: it works from the captured operands.
  always_comb begin
    b_eff_s     = b_r;
    sum_s       = ALL_ZERO;
    add_ovf_s   = 1'b0;
    slt_s       = 1'b0;
    exec_rslt_s = ALL_ZERO;
    exec_ovf_s  = 1'b0;

    // SUB shares the adder by using the two's complement of B.
    if (op_r == OP_SUB) begin
      b_eff_s = ~b_r + ONE_W;
    end else begin
      b_eff_s = b_r;
    end
    sum_s     = a_r + b_eff_s;
    add_ovf_s = (a_r[MSB] == b_eff_s[MSB]) && (sum_s[MSB] != a_r[MSB]);

    // A true signed compare stays correct when A-B overflows.
    slt_s = ($signed(a_r) < $signed(b_r));

    case (op_r)
      OP_AND: begin
        exec_rslt_s = a_r & b_r;
      end
      OP_OR: begin
        exec_rslt_s = a_r | b_r;
      end
      OP_ADD, OP_SUB: begin
        exec_rslt_s = sum_s;
        exec_ovf_s  = add_ovf_s;
      end
      OP_SLT: begin
        exec_rslt_s = {{(WIDTH-1){1'b0}}, slt_s};
      end
      OP_SLL: begin
        exec_rslt_s = a_r << b_r[SH_W-1:0];
      end
      OP_SRL: begin
        exec_rslt_s = a_r >> b_r[SH_W-1:0];
      end
      // OP_MUL reaches this path only when the multiplier is absent.
      default: begin
        exec_rslt_s = ALL_ZERO;
        exec_ovf_s  = 1'b0;
      end
    endcase
  end

  // Control FSM, operand capture, multiplier iterations and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_r      <= ALL_ZERO;
      b_r      <= ALL_ZERO;
      op_r     <= OP_AND;
      busy     <= 1'b0;
      done     <= 1'b0;
      aluRslt  <= ALL_ZERO;
      zero     <= 1'b1;
      ovf      <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_r    <= CNT_ZERO;
      acc_r    <= ALL_ZERO;
      mcand_r  <= ALL_ZERO;
      mplier_r <= ALL_ZERO;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r  <= srcA;
            b_r  <= srcB;
            op_r <= aluCtrl;
            busy <= 1'b1;
`ifdef ALU_MUL_EN
            if (aluCtrl == OP_MUL) begin
              state_r  <= ST_MUL;
              cnt_r    <= CNT_ZERO;
              acc_r    <= ALL_ZERO;
              mcand_r  <= srcA;
              mplier_r <= srcB;
            end else begin
              state_r <= ST_EXEC;
            end
`else
            state_r <= ST_EXEC;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_EXEC: begin
          aluRslt <= exec_rslt_s;
          zero    <= (exec_rslt_s == ALL_ZERO);
          ovf     <= exec_ovf_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (cnt_r == CNT_LAST) begin
            aluRslt <= acc_r;
            zero    <= (acc_r == ALL_ZERO);
            ovf     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_IDLE;
          end else begin
            // One shift-add step: add the shifted multiplicand for each
            // set multiplier bit, LSB first. Only the low WIDTH bits are kept.
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end else begin
              acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end
`endif

        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH = 32).
//
// A behavioural reference computes each operation's result, overflow and
// latency arithmetically. A cycle model then tracks when done must pulse. A
// compare thread checks busy/done/aluRslt/zero/ovf on every falling edge.
// Directed vectors also check hand-computed literal results and latencies.
// Build with +define+ALU_MUL_EN to check the multiplier build.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam int MUL_LAT = MUL_ON ? W + 1 : 1;
  localparam int PRE_RST = MUL_ON ? 10 : 0;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [W-1:0] srcA    = '0;
  logic [W-1:0] srcB    = '0;
  logic [2:0]   aluCtrl = 3'b000;
  logic         busy, done, zero, ovf;
  logic [W-1:0] aluRslt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Cycle-level reference state.
  logic         m_busy, m_done, m_ovf, m_pend_ovf;
  logic [W-1:0] m_rslt, m_pend;
  int           m_left;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .srcA(srcA), .srcB(srcB),
    .aluCtrl(aluCtrl), .busy(busy), .done(done), .aluRslt(aluRslt),
    .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_rslt(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
    longint sa, sb;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = (sa < sb) ? 32'd1 : 32'd0;
      3'b100:  r = a << (b % 32);
      3'b101:  r = a >> (b % 32);
      3'b011:  r = MUL_ON ? a * b : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
    longint s;
    case (op)
      3'b010:  s = longint'($signed(a)) + longint'($signed(b));
      3'b110:  s = longint'($signed(a)) - longint'($signed(b));
      default: return 1'b0;
    endcase
    return (s > SMAX) || (s < SMIN);
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    return (op == 3'b011) ? MUL_LAT : 1;
  endfunction

  // Reference timing: an accepted request completes ref_lat edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rslt <= '0; m_ovf <= 1'b0;
      m_left <= 0; m_pend <= '0; m_pend_ovf <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy     <= 1'b1;
          m_left     <= ref_lat(aluCtrl);
          m_pend     <= ref_rslt(srcA, srcB, aluCtrl);
          m_pend_ovf <= ref_ovf(srcA, srcB, aluCtrl);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_rslt <= m_pend;
        m_ovf  <= m_pend_ovf;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for done, checking just after each rising edge, for at most 200 cycles.
  task automatic wait_done(output int lat, output bit found);
    lat = 0;
    found = 1'b0;
    while (!found && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] exp_r,
                        input logic exp_o, input int exp_lat);
    int lat;
    bit found;
    @(negedge clk);
    srcA = a; srcB = b; aluCtrl = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, found);
    chk_bit({name, "_done"}, found, 1'b1);
    chk_int({name, "_lat"}, lat, exp_lat);
    chk_val({name, "_rslt"}, aluRslt, exp_r);
    chk_bit({name, "_ovf"}, ovf, exp_o);
    chk_bit({name, "_zero"}, zero, exp_r == '0);
  endtask

  // Holds start high with junk operands for the whole busy window.
  task automatic busy_ignore(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op, input logic [W-1:0] exp_r, input int exp_lat);
    int lat, extra;
    bit found;
    @(negedge clk);
    srcA = a; srcB = b; aluCtrl = op; start = 1'b1;
    @(posedge clk); #1;
    srcA = 32'hDEAD_BEEF; srcB = 32'h0000_0001; aluCtrl = 3'b010;
    wait_done(lat, found);
    start = 1'b0;
    chk_bit({name, "_done"}, found, 1'b1);
    chk_int({name, "_lat"}, lat, exp_lat);
    chk_val({name, "_rslt"}, aluRslt, exp_r);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    chk_int({name, "_extra"}, extra, 0);
  endtask

  initial begin
    logic [W-1:0] ba [4];
    logic [W-1:0] bb [4];
    logic [W-1:0] bexp [4];
    logic [2:0]   bop [4];
    int           blat [4];
    int           lat, ndone, extra;
    bit           found;

    fork
      begin
        forever begin
          @(negedge clk);
          if (chk_en) begin
            chk_bit("cyc_busy", busy, m_busy);
            chk_bit("cyc_done", done, m_done);
            chk_val("cyc_rslt", aluRslt, m_rslt);
            chk_bit("cyc_zero", zero, m_rslt == '0);
            chk_bit("cyc_ovf", ovf, m_ovf);
          end
        end
      end
    join_none

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_val("rst_rslt", aluRslt, 32'h0);
    chk_bit("rst_zero", zero, 1'b1);
    chk_bit("rst_ovf", ovf, 1'b0);
    chk_en = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Single-cycle operations on one operand pair.
    run_op("and", 32'h0AAAAA2A, 32'h04538D14, 3'b000, 32'h00028800, 1'b0, 1);
    run_op("or",  32'h0AAAAA2A, 32'h04538D14, 3'b001, 32'h0EFBAF3E, 1'b0, 1);
    run_op("add", 32'h0AAAAA2A, 32'h04538D14, 3'b010, 32'h0EFE373E, 1'b0, 1);
    run_op("sub", 32'h0AAAAA2A, 32'h04538D14, 3'b110, 32'h06571D16, 1'b0, 1);
    run_op("slt", 32'h0AAAAA2A, 32'h04538D14, 3'b111, 32'h00000000, 1'b0, 1);

    // Flags and boundaries.
    run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b1, 1);
    run_op("sub_zero", 32'h12345678, 32'h12345678, 3'b110, 32'h00000000, 1'b0, 1);
    run_op("sub_ovf",  32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b1, 1);
    run_op("slt_neg",  32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1);
    run_op("slt_wrap", 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1);
    run_op("slt_wrp2", 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b0, 1);
    run_op("sll",      32'h00000001, 32'h00000024, 3'b100, 32'h00000010, 1'b0, 1);
    run_op("srl",      32'h80000000, 32'h0000003F, 3'b101, 32'h00000001, 1'b0, 1);

    // Multiply (zero with one-cycle latency when the multiplier is absent).
    run_op("mul_7x9", 32'h00000007, 32'h00000009, 3'b011,
           MUL_ON ? 32'h0000003F : 32'h0, 1'b0, MUL_LAT);
    run_op("mul_big", 32'hFFFFFFFF, 32'h00000002, 3'b011,
           MUL_ON ? 32'hFFFFFFFE : 32'h0, 1'b0, MUL_LAT);

    // Start during busy must be ignored.
    busy_ignore("busy_add", 32'h00000005, 32'h00000006, 3'b010, 32'h0000000B, 1);
    busy_ignore("busy_mul", 32'h00000006, 32'h00000007, 3'b011,
                MUL_ON ? 32'h0000002A : 32'h0, MUL_LAT);
    run_op("pre_rst", 32'h00000005, 32'h00000006, 3'b010, 32'h0000000B, 1'b0, 1);

    // Reset while an operation is in flight.
    @(negedge clk);
    srcA = 32'h00001234; srcB = 32'h00005678; aluCtrl = MUL_ON ? 3'b011 : 3'b010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PRE_RST) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_done", done, 1'b0);
    chk_val("mid_rst_rslt", aluRslt, 32'h0);
    chk_bit("mid_rst_zero", zero, 1'b1);
    chk_bit("mid_rst_ovf", ovf, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    chk_int("mid_rst_nodone", extra, 0);
    run_op("mul_3x5", 32'h00000003, 32'h00000005, 3'b011,
           MUL_ON ? 32'h0000000F : 32'h0, 1'b0, MUL_LAT);

    // Back-to-back requests with start held high.
    ba[0] = 32'h0AAAAA2A; bb[0] = 32'h04538D14; bop[0] = 3'b010; bexp[0] = 32'h0EFE373E; blat[0] = 1;
    ba[1] = 32'h0AAAAA2A; bb[1] = 32'h04538D14; bop[1] = 3'b000; bexp[1] = 32'h00028800; blat[1] = 1;
    ba[2] = 32'h00000007; bb[2] = 32'h00000009; bop[2] = 3'b011;
    bexp[2] = MUL_ON ? 32'h0000003F : 32'h0; blat[2] = MUL_LAT;
    ba[3] = 32'h0AAAAA2A; bb[3] = 32'h04538D14; bop[3] = 3'b001; bexp[3] = 32'h0EFBAF3E; blat[3] = 1;
    @(negedge clk);
    srcA = ba[0]; srcB = bb[0]; aluCtrl = bop[0]; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        srcA = ba[i+1]; srcB = bb[i+1]; aluCtrl = bop[i+1];
      end else begin
        start = 1'b0;
      end
      wait_done(lat, found);
      if (found) ndone++;
      chk_int($sformatf("b2b_lat%0d", i), lat, blat[i]);
      chk_val($sformatf("b2b_rslt%0d", i), aluRslt, bexp[i]);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    chk_int("b2b_dones", ndone, 4);
    chk_int("b2b_extra", extra, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
